// File: rtl/hdr_parse_engine.sv
// Header-chain parser: walks a packet through the memory read port, following per-header
// next-tag tables, and records the absolute offset of every header it recognises.
module hdr_parse_engine #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_HDR      = 8,
  parameter int NEXT_ENTRIES = 2,
  parameter int TAG_W        = 16,
  parameter int ID_W         = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start_i,
  input  logic [ADDR_W-1:0]                pkt_addr_i,
  output logic                             mem_ce_o,
  output logic                             mem_we_o,
  output logic [ADDR_W-1:0]                mem_addr_o,
  output logic [3:0]                       mem_width_o,
  output logic [DATA_W-1:0]                mem_data_o,
  input  logic [DATA_W-1:0]                mem_data_i,
  input  logic                             ps_mod_start_i,
  input  logic [DATA_W-1:0]                ps_mod_hdr_id_i,
  input  logic [DATA_W-1:0]                ps_mod_hdr_len_i,
  input  logic [DATA_W-1:0]                ps_mod_next_tag_start_i,
  input  logic [DATA_W-1:0]                ps_mod_next_tag_len_i,
  input  logic [NEXT_ENTRIES*(TAG_W+ID_W)-1:0] ps_mod_next_table_i,
  output logic                             ready_o,
  output logic                             err_o,
  output logic [MAX_HDR-1:0]               hdr_valid_o,
  output logic [MAX_HDR*ADDR_W-1:0]        hdr_off_o
);

  // state  | meaning
  // IDLE   | waiting for start_i
  // FETCH  | check tag_len of current header, issue tag read
  // WAIT   | read in flight
  // LOOKUP | match returned tag against next table
  // DONE   | results valid, wait for start_i low
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_LOOKUP, S_DONE} state_t;

  localparam int IDX_W = (MAX_HDR > 1) ? $clog2(MAX_HDR) : 1;
  localparam int EW    = TAG_W + ID_W;
  localparam logic [ID_W-1:0]   NO_NEXT = '1;
  localparam logic [DATA_W-1:0] TAG_B   = DATA_W'(TAG_W / 8);

  logic [DATA_W-1:0]          hdr_len   [MAX_HDR];
  logic [DATA_W-1:0]          tag_start [MAX_HDR];
  logic [DATA_W-1:0]          tag_len   [MAX_HDR];
  logic [NEXT_ENTRIES*EW-1:0] next_tbl  [MAX_HDR];

  state_t              state;
  logic [IDX_W-1:0]    cur_id;
  logic [ADDR_W-1:0]   cur_addr;
  logic [IDX_W-1:0]    wr_idx;
  logic [TAG_W-1:0]    tag;
  logic [NEXT_ENTRIES*EW-1:0] cur_next;
  logic                hit;
  logic [ID_W-1:0]     hit_id;
  logic [ADDR_W-1:0]   next_addr;
  logic                unused_bits;

  assign wr_idx      = ps_mod_hdr_id_i[IDX_W-1:0];
  assign tag         = mem_data_i[TAG_W-1:0];
  assign cur_next    = next_tbl[cur_id];
  assign next_addr   = cur_addr + ADDR_W'(hdr_len[cur_id]);
  assign mem_we_o    = 1'b0;
  assign mem_data_o  = '0;
  assign unused_bits = ^{ps_mod_hdr_id_i[DATA_W-1:IDX_W], mem_data_i[DATA_W-1:TAG_W]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_HDR; i++) begin
        hdr_len[i]   <= '0;
        tag_start[i] <= '0;
        tag_len[i]   <= '0;
        next_tbl[i]  <= '1;
      end
    end else if (ps_mod_start_i) begin
      hdr_len[wr_idx]   <= ps_mod_hdr_len_i;
      tag_start[wr_idx] <= ps_mod_next_tag_start_i;
      tag_len[wr_idx]   <= ps_mod_next_tag_len_i;
      next_tbl[wr_idx]  <= ps_mod_next_table_i;
    end
  end

  // Read data arrives in the LOOKUP cycle; walking down from the top lets entry 0 win ties.
  always_comb begin
    hit    = 1'b0;
    hit_id = NO_NEXT;
    for (int k = NEXT_ENTRIES - 1; k >= 0; k--) begin
      if (cur_next[(NEXT_ENTRIES-k)*EW-TAG_W-1 -: ID_W] != NO_NEXT &&
          cur_next[(NEXT_ENTRIES-k)*EW-1 -: TAG_W] == tag) begin
        hit    = 1'b1;
        hit_id = cur_next[(NEXT_ENTRIES-k)*EW-TAG_W-1 -: ID_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cur_id      <= '0;
      cur_addr    <= '0;
      mem_ce_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_width_o <= '0;
      ready_o     <= 1'b0;
      err_o       <= 1'b0;
      hdr_valid_o <= '0;
      hdr_off_o   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            ready_o                 <= 1'b0;
            err_o                   <= 1'b0;
            hdr_valid_o             <= MAX_HDR'(1);
            hdr_off_o[0 +: ADDR_W]  <= pkt_addr_i;
            cur_id                  <= '0;
            cur_addr                <= pkt_addr_i;
            state                   <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (tag_len[cur_id] == '0) begin
            state <= S_DONE;
          end else if (tag_len[cur_id] > TAG_B) begin
            err_o <= 1'b1;
            state <= S_DONE;
          end else begin
            mem_ce_o    <= 1'b1;
            mem_addr_o  <= cur_addr + ADDR_W'(tag_start[cur_id]);
            mem_width_o <= tag_len[cur_id][3:0];
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          mem_ce_o <= 1'b0;
          state    <= S_LOOKUP;
        end
        S_LOOKUP: begin
          if (!hit) begin
            state <= S_DONE;
          end else if (hit_id >= ID_W'(MAX_HDR) || hdr_valid_o[hit_id[IDX_W-1:0]]) begin
            err_o <= 1'b1;
            state <= S_DONE;
          end else begin
            cur_addr                                    <= next_addr;
            cur_id                                      <= hit_id[IDX_W-1:0];
            hdr_valid_o[hit_id[IDX_W-1:0]]              <= 1'b1;
            hdr_off_o[hit_id[IDX_W-1:0]*ADDR_W +: ADDR_W] <= next_addr;
            state                                       <= S_FETCH;
          end
        end
        S_DONE: begin
          ready_o <= 1'b1;
          if (!start_i) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hdr_parse_engine.sv
// Scoreboarded bench for hdr_parse_engine: expected parse results are queued at start and
// compared when ready_o rises, alongside a byte-addressed memory model.
module tb_hdr_parse_engine;
  localparam int ADDR_W = 32, DATA_W = 32, MAX_HDR = 8, NE = 2, TAG_W = 16, ID_W = 16;
  localparam logic [15:0] NN = 16'hFFFF;

  logic clk = 1'b0;
  logic rst;
  logic start, ce, we, ps_start, ready, err;
  logic [ADDR_W-1:0] pkt_addr, maddr;
  logic [3:0] mwidth;
  logic [DATA_W-1:0] mdata_out, ps_id, ps_len, ps_tstart, ps_tlen;
  logic [NE*(TAG_W+ID_W)-1:0] ps_tbl;
  logic [MAX_HDR-1:0] valid;
  logic [MAX_HDR*ADDR_W-1:0] off;

  logic [7:0]  pmem [256];
  logic [31:0] mem_rd = '0;
  int          fetch_cnt = 0;
  logic [31:0] last_addr = '0;
  logic [3:0]  last_w = '0;

  typedef struct packed {
    logic [7:0]       valid;
    logic             err;
    logic [7:0][31:0] off;
    logic [7:0]       lat;
    logic [7:0]       nfetch;
  } exp_t;
  exp_t sb[$];

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  hdr_parse_engine dut (
    .clk(clk), .rst(rst), .start_i(start), .pkt_addr_i(pkt_addr),
    .mem_ce_o(ce), .mem_we_o(we), .mem_addr_o(maddr), .mem_width_o(mwidth),
    .mem_data_o(mdata_out), .mem_data_i(mem_rd),
    .ps_mod_start_i(ps_start), .ps_mod_hdr_id_i(ps_id), .ps_mod_hdr_len_i(ps_len),
    .ps_mod_next_tag_start_i(ps_tstart), .ps_mod_next_tag_len_i(ps_tlen),
    .ps_mod_next_table_i(ps_tbl),
    .ready_o(ready), .err_o(err), .hdr_valid_o(valid), .hdr_off_o(off)
  );

  function automatic logic [31:0] rd_bytes(input logic [31:0] a, input logic [3:0] w);
    logic [31:0] d = '0;
    for (int i = 0; i < 4; i++)
      if (i < int'(w)) d = {d[23:0], pmem[8'(a + 32'(i))]};
    return d;
  endfunction

  always @(posedge clk) begin
    if (ce) begin
      mem_rd    <= rd_bytes(maddr, mwidth);
      fetch_cnt <= fetch_cnt + 1;
      last_addr <= maddr;
      last_w    <= mwidth;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cfg(input int id, input int len, input int ts, input int tl,
                     input logic [15:0] t0, input logic [15:0] i0,
                     input logic [15:0] t1, input logic [15:0] i1);
    @(negedge clk);
    ps_id = 32'(id); ps_len = 32'(len); ps_tstart = 32'(ts); ps_tlen = 32'(tl);
    ps_tbl = {t0, i0, t1, i1};
    ps_start = 1'b1;
    @(negedge clk);
    ps_start = 1'b0;
  endtask

  function automatic exp_t mk(input logic [7:0] v, input logic e, input int lat, input int nf);
    exp_t x = '0;
    x.valid = v; x.err = e; x.lat = 8'(lat); x.nfetch = 8'(nf);
    return x;
  endfunction

  // Drives start, leaves it high; caller decides when to drop it.
  task automatic run(input string name, input logic [31:0] addr, input exp_t e);
    exp_t x;
    int n, fc0;
    sb.push_back(e);
    fc0 = fetch_cnt;
    @(negedge clk);
    start = 1'b1; pkt_addr = addr;
    @(posedge clk);
    #1;
    n = 0;
    while (!ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    x = sb.pop_front();
    chk({name, "_ready"}, ready, 1'b1);
    chk({name, "_lat"}, n, x.lat);
    chk({name, "_valid"}, valid, x.valid);
    chk({name, "_err"}, err, x.err);
    chk({name, "_fetches"}, fetch_cnt - fc0, x.nfetch);
    for (int i = 0; i < MAX_HDR; i++)
      if (x.valid[i]) chk($sformatf("%s_off%0d", name, i), off[i*32 +: 32], x.off[i]);
  endtask

  task automatic drop_start();
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    exp_t e;
    int fc;
    for (int i = 0; i < 256; i++) pmem[i] = 8'h00;
    rst = 1'b1; start = 1'b0; pkt_addr = '0; ps_start = 1'b0;
    ps_id = '0; ps_len = '0; ps_tstart = '0; ps_tlen = '0; ps_tbl = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", ready, 0); chk("rst_err", err, 0); chk("rst_valid", valid, 0);
    chk("rst_ce", ce, 0); chk("rst_off", off[63:0], 0);
    @(negedge clk); rst = 1'b0;

    // Eth/IPv4 packet at 4: ethertype 0x0800 at bytes 16..17, IPv4 tag byte at 29
    pmem[16] = 8'h08; pmem[17] = 8'h00; pmem[29] = 8'h06;
    cfg(0, 14, 12, 2, 16'h0800, 16'd1, 16'h0000, NN);
    cfg(1, 20, 11, 1, 16'h0000, NN, 16'h0000, NN);
    e = mk(8'b11, 0, 7, 2); e.off[0] = 4; e.off[1] = 18;
    run("eth", 32'd4, e);
    chk("eth_last_addr", last_addr, 32'h1D);
    chk("eth_last_w", last_w, 4'd1);
    chk("mem_we", we, 0);
    chk("mem_dout", mdata_out, 0);
    drop_start();

    pmem[16] = 8'h86; pmem[17] = 8'hDD;
    e = mk(8'b01, 0, 4, 1); e.off[0] = 4;
    run("miss", 32'd4, e);
    drop_start();

    pmem[16] = 8'h08; pmem[17] = 8'h00;
    cfg(1, 20, 11, 1, 16'h0006, 16'd0, 16'h0000, NN);
    e = mk(8'b11, 1, 7, 2); e.off[0] = 4; e.off[1] = 18;
    run("loop", 32'd4, e);
    drop_start();

    cfg(0, 14, 12, 2, 16'h0800, 16'd8, 16'h0000, NN);
    e = mk(8'b01, 1, 4, 1); e.off[0] = 4;
    run("badid", 32'd4, e);
    drop_start();

    cfg(0, 14, 12, 3, 16'h0800, 16'd1, 16'h0000, NN);
    e = mk(8'b01, 1, 2, 0); e.off[0] = 4;
    run("badlen", 32'd4, e);
    drop_start();

    // Both entries match: entry 0 (id 3) must win over entry 1 (id 2)
    cfg(0, 14, 12, 2, 16'h0800, 16'd3, 16'h0800, 16'd2);
    cfg(3, 0, 0, 0, 16'h0000, NN, 16'h0000, NN);
    e = mk(8'b1001, 0, 5, 1); e.off[0] = 4; e.off[3] = 18;
    run("prio", 32'd4, e);
    drop_start();

    // Entry 0 unused, entry 1 matches
    cfg(0, 14, 12, 2, 16'h0800, NN, 16'h0800, 16'd2);
    cfg(2, 0, 0, 0, 16'h0000, NN, 16'h0000, NN);
    e = mk(8'b101, 0, 5, 1); e.off[0] = 4; e.off[2] = 18;
    run("ent1", 32'd4, e);
    drop_start();

    // Address wraps past 2^32
    pmem[4] = 8'h08; pmem[5] = 8'h00;
    cfg(0, 14, 12, 2, 16'h0800, 16'd1, 16'h0000, NN);
    cfg(1, 20, 11, 1, 16'h0000, NN, 16'h0000, NN);
    e = mk(8'b11, 0, 7, 2); e.off[0] = 32'hFFFF_FFF8; e.off[1] = 32'd6;
    run("wrap", 32'hFFFF_FFF8, e);
    chk("wrap_last_addr", last_addr, 32'd17);

    // Handshake: start held high after ready must not restart
    fc = fetch_cnt;
    repeat (5) @(posedge clk);
    #1;
    chk("hold_ready", ready, 1);
    chk("hold_valid", valid, 8'b11);
    chk("hold_nofetch", fetch_cnt - fc, 0);
    drop_start();
    chk("idle_ready_kept", ready, 1);
    cfg(0, 14, 12, 0, 16'h0800, 16'd1, 16'h0000, NN);
    e = mk(8'b01, 0, 2, 0); e.off[0] = 32'd40;
    run("restart", 32'd40, e);
    drop_start();

    // Reset mid-parse
    cfg(0, 14, 12, 2, 16'h0800, 16'd1, 16'h0000, NN);
    @(negedge clk);
    start = 1'b1; pkt_addr = 32'd4;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_valid", valid, 0); chk("mid_rst_ce", ce, 0);
    chk("mid_rst_off", off[31:0], 0); chk("mid_rst_err", err, 0);
    start = 1'b0;
    @(negedge clk); rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_ready", ready, 0);
    e = mk(8'b01, 0, 2, 0); e.off[0] = 4;
    run("cleared", 32'd4, e);
    drop_start();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
